spi_display_ctrl: RTL
=====================

Name: spi_display_ctrl

Overview:
Command controller between the SPI byte interface and the 4-digit 7-segment display driver. It parses a byte-oriented command stream from the SPI receiver and owns the digit and colon registers that feed the display interface. It also loads reply bytes for the SPI transmitter and can run the display as a free-running BCD counter advanced by an external tick. It replaces ad-hoc digit and reply logic in the top level with one sequenced owner of the display state.

Parameters:
TIMEOUT, 16000, clk cycles allowed between bytes of a multi-byte command before it is aborted (valid range 2 to 65535)
DEFAULT_COLON, 2'b11, reset value of colon (00 colon, 01 decimal point, 11 none)

Ports:
clk  in  1  system clock; all logic on posedge
reset_n  in  1  asynchronous active-low reset
rx_valid  in  1  one-cycle pulse: rx_data holds a received SPI byte
rx_data  in  8  received byte
tick  in  1  one-cycle pulse; advances the counter when auto mode is on
tx_valid  out  1  one-cycle pulse: tx_data is the reply for the next SPI transfer
tx_data  out  8  reply byte, held until the next tx_valid
digit0..digit3  out  4 each  BCD digits to the display driver; digit0 is the LSD
colon  out  2  colon/decimal-point code to the display driver
auto_en  out  1  auto-count mode active
error  out  1  one-cycle pulse on a protocol error
busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset values (asserted asynchronously by reset_n low): state IDLE; digits 0; colon DEFAULT_COLON; auto_en 0; tx_valid 0; tx_data 8'h00; error 0; timeout counter 0; hold register 0.
- States: IDLE, ARG (waiting for an argument byte; latched cmd), RD2 (waiting for the second read byte).
- Reply latency: tx_valid pulses for exactly 1 cycle, in the cycle after the rx_valid cycle. tx_data updates in the same cycle.
- A new rx_valid is accepted on every cycle, including back-to-back cycles.
- IDLE, command byte decode:
  - 8'h00 NOP: reply 8'h00; stay IDLE.
  - 8'h10-8'h13 WR_DIGIT n=rx_data[1:0]: reply 8'hA5; go to ARG.
  - 8'h20 WR_COLON: reply 8'hA5; go to ARG.
  - 8'h21 WR_MODE: reply 8'hA5; go to ARG.
  - 8'h30 READ: reply {digit1,digit0}; latch {digit3,digit2} into the hold register in the same cycle; go to RD2.
  - Any other value: reply 8'hEE; error pulse; stay IDLE.
- ARG, argument byte; always return to IDLE:
  - WR_DIGIT: if arg[3:0] <= 9, write digit n and reply 8'hA5. Otherwise reply 8'hEE, pulse error, digit unchanged. arg[7:4] is ignored.
  - WR_COLON: colon <= arg[1:0]; reply 8'hA5.
  - WR_MODE: auto_en <= arg[0]; reply 8'hA5.
- RD2: any byte (content ignored) gets reply = hold register. Return to IDLE. The displayed value is a tear-free snapshot from the command cycle.
- Timeout:
  - The counter clears on every rx_valid and is held at 0 in IDLE.
  - In ARG or RD2, it increments each cycle without rx_valid.
  - When the count reaches TIMEOUT-1: go to IDLE, pulse error, no tx_valid, no register change.
  - A byte arriving in the same cycle as the expiry is treated as a new IDLE command byte.
- Auto count: when auto_en=1 and tick=1, the 4-digit BCD value increments by 1.
  - Per-digit carry: 9 -> 0 with carry into the next digit.
  - 9999 wraps to 0000.
  - tick is ignored when auto_en=0.
- Simultaneous events:
  - A WR_DIGIT argument write and tick in the same cycle: the write applies, and that tick is dropped entirely (no digit increments).
  - READ and tick in the same cycle: the snapshot and the reply use the pre-increment value.
- Reset mid-command: all state returns to reset values immediately. A partially received command is discarded.

Test Plan:
1. Release reset, no stimulus -> digits 0000, colon 2'b11, auto_en 0, tx_valid never asserted.
2. Bytes 8'h12 then 8'h07 -> replies 8'hA5, 8'hA5; digit2=7, other digits 0; each tx_valid occurs 1 cycle after its rx_valid.
3. Bytes 8'h11 then 8'h0C -> second reply 8'hEE with one error pulse; digit1 unchanged. Byte 8'h55 -> reply 8'hEE plus error.
4. Preset digits 9,9,9,8 (d3..d0), send 8'h21 then 8'h01, apply 2 ticks -> 9999 then 0000. Tick coincident with a WR_DIGIT argument -> write value applies, no increment.
5. Digits 1234, send 8'h30 -> reply 8'h34. Tick to 1235 before the second byte -> second reply 8'h12 (snapshot); state returns to IDLE.
6. Send 8'h20, then idle TIMEOUT cycles -> error pulse, busy drops, colon unchanged. The next byte is decoded as a command.

Source files
------------

// File: rtl/spi_display_ctrl_if.sv
// spi_display_ctrl_if
// Byte handshake between the SPI shift logic and the display command
// controller.
//   rx_valid / rx_data : received byte, one-cycle strobe (SPI side -> ctrl)
//   tx_valid / tx_data : reply byte for the next transfer (ctrl -> SPI side)
// The master modport is the SPI side; the slave modport is the controller.
interface spi_display_ctrl_if;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       tx_valid;
    logic [7:0] tx_data;

    modport master (output rx_valid, output rx_data, input tx_valid, input tx_data);
    modport slave  (input rx_valid, input rx_data, output tx_valid, output tx_data);
endinterface

// File: rtl/spi_display_ctrl.sv
// spi_display_ctrl
// Parses the SPI command byte stream, owns the four BCD digits and the colon
// code driven to the 7-segment driver, produces reply bytes, and optionally
// runs the digits as a free-running BCD counter advanced by tick.
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   bus (slave)           rx byte strobe in, tx reply strobe out
//   tick                  counter advance pulse (used when auto_en = 1)
//   digit0..digit3        BCD digits, digit0 least significant
//   colon                 colon / decimal-point code
//   auto_en               auto-count mode
//   error                 one-cycle protocol error / timeout pulse
//   busy                  a multi-byte command is in progress
//
// state | meaning
// IDLE  | next byte is a command
// ARG   | waiting for the argument of the latched command
// RD2   | waiting for the second byte of a READ; replies with the snapshot
module spi_display_ctrl #(
    parameter int         TIMEOUT       = 16000,
    parameter logic [1:0] DEFAULT_COLON = 2'b11
) (
    input  logic              clk,
    input  logic              reset_n,
    spi_display_ctrl_if.slave bus,
    input  logic              tick,
    output logic [3:0]        digit0,
    output logic [3:0]        digit1,
    output logic [3:0]        digit2,
    output logic [3:0]        digit3,
    output logic [1:0]        colon,
    output logic              auto_en,
    output logic              error,
    output logic              busy
);
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ARG, RD2} state_t;
    typedef enum logic [1:0] {C_DIGIT, C_COLON, C_MODE} cmd_t;

    state_t      state_q, state_d;
    cmd_t        cmd_q, cmd_new;
    logic [1:0]  sel_q;
    logic [15:0] cnt_q;
    logic [7:0]  hold_q;
    logic [3:0]  dig_q   [4];
    logic [3:0]  dig_inc [4];
    logic        carry;
    logic        tx_valid_q;
    logic [7:0]  tx_data_q;

    logic        expire, eff_idle;
    logic        reply_v, err_d, wr_dig, wr_col, wr_mode, snap, cmd_ld;
    logic [7:0]  reply;

    // An expiring command frees the parser in the same cycle, so a byte
    // arriving then is decoded as a fresh command.
    assign expire   = (state_q != IDLE) && (cnt_q == TO_LAST);
    assign eff_idle = (state_q == IDLE) || expire;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (bus.rx_valid) begin
            if (eff_idle) begin
                case (bus.rx_data)
                    8'h10, 8'h11, 8'h12, 8'h13,
                    8'h20, 8'h21: state_d = ARG;
                    8'h30:        state_d = RD2;
                    default:      state_d = IDLE;
                endcase
            end else begin
                state_d = IDLE;
            end
        end else if (expire) begin
            state_d = IDLE;
        end
    end

    always_comb begin
        reply   = 8'h00;
        reply_v = 1'b0;
        err_d   = expire;
        wr_dig  = 1'b0;
        wr_col  = 1'b0;
        wr_mode = 1'b0;
        snap    = 1'b0;
        cmd_ld  = 1'b0;
        cmd_new = C_DIGIT;
        if (bus.rx_valid) begin
            reply_v = 1'b1;
            if (eff_idle) begin
                case (bus.rx_data)
                    8'h00: reply = 8'h00;
                    8'h10, 8'h11, 8'h12, 8'h13: begin
                        reply  = 8'hA5;
                        cmd_ld = 1'b1;
                        cmd_new = C_DIGIT;
                    end
                    8'h20: begin
                        reply  = 8'hA5;
                        cmd_ld = 1'b1;
                        cmd_new = C_COLON;
                    end
                    8'h21: begin
                        reply  = 8'hA5;
                        cmd_ld = 1'b1;
                        cmd_new = C_MODE;
                    end
                    8'h30: begin
                        reply = {dig_q[1], dig_q[0]};
                        snap  = 1'b1;
                    end
                    default: begin
                        reply = 8'hEE;
                        err_d = 1'b1;
                    end
                endcase
            end else if (state_q == ARG) begin
                case (cmd_q)
                    C_DIGIT: begin
                        if (bus.rx_data[3:0] <= 4'd9) begin
                            wr_dig = 1'b1;
                            reply  = 8'hA5;
                        end else begin
                            reply = 8'hEE;
                            err_d = 1'b1;
                        end
                    end
                    C_COLON: begin
                        wr_col = 1'b1;
                        reply  = 8'hA5;
                    end
                    default: begin
                        wr_mode = 1'b1;
                        reply   = 8'hA5;
                    end
                endcase
            end else begin
                reply = hold_q;
            end
        end
    end

    // Ripple BCD increment; 9999 rolls over to 0000.
    always_comb begin
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            dig_inc[i] = dig_q[i];
            if (carry) begin
                if (dig_q[i] == 4'd9) begin
                    dig_inc[i] = 4'd0;
                end else begin
                    dig_inc[i] = dig_q[i] + 4'd1;
                    carry      = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
            error      <= 1'b0;
            cnt_q      <= '0;
            hold_q     <= 8'h00;
            cmd_q      <= C_DIGIT;
            sel_q      <= 2'd0;
            colon      <= DEFAULT_COLON;
            auto_en    <= 1'b0;
            for (int i = 0; i < 4; i++) dig_q[i] <= 4'd0;
        end else begin
            tx_valid_q <= reply_v;
            if (reply_v) tx_data_q <= reply;
            error <= err_d;
            cnt_q <= (bus.rx_valid || state_q == IDLE || expire) ? 16'd0 : cnt_q + 16'd1;
            if (cmd_ld) begin
                cmd_q <= cmd_new;
                sel_q <= bus.rx_data[1:0];
            end
            if (snap)    hold_q  <= {dig_q[3], dig_q[2]};
            if (wr_col)  colon   <= bus.rx_data[1:0];
            if (wr_mode) auto_en <= bus.rx_data[0];
            // A digit write wins over a coincident tick; that tick is lost.
            if (wr_dig)                    dig_q[sel_q] <= bus.rx_data[3:0];
            else if (auto_en && tick)      dig_q <= dig_inc;
        end
    end

    assign bus.tx_valid = tx_valid_q;
    assign bus.tx_data  = tx_data_q;
    assign busy   = (state_q != IDLE);
    assign digit0 = dig_q[0];
    assign digit1 = dig_q[1];
    assign digit2 = dig_q[2];
    assign digit3 = dig_q[3];
endmodule
